// File: rtl/alu_arbiter_if.sv
// Request/response channels for both requesters plus the shared ALU bus of alu_arbiter.
// slave = arbiter side, master = requesters/ALU side.
interface alu_arbiter_if #(
  parameter int WIDTH  = 64,
  parameter int CTRL_W = 4
);
  logic              req0_valid;
  logic              req0_ready;
  logic [WIDTH-1:0]  req0_a;
  logic [WIDTH-1:0]  req0_b;
  logic [CTRL_W-1:0] req0_ctrl;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [WIDTH-1:0]  rsp0_result;
  logic              rsp0_zero;
  logic              rsp0_err;

  logic              req1_valid;
  logic              req1_ready;
  logic [WIDTH-1:0]  req1_a;
  logic [WIDTH-1:0]  req1_b;
  logic [CTRL_W-1:0] req1_ctrl;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [WIDTH-1:0]  rsp1_result;
  logic              rsp1_zero;
  logic              rsp1_err;

  logic [WIDTH-1:0]  alu_busA;
  logic [WIDTH-1:0]  alu_busB;
  logic [CTRL_W-1:0] alu_ctrl;
  logic [WIDTH-1:0]  alu_busW;
  logic              alu_zero;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_ctrl, rsp0_ready,
    input  req1_valid, req1_a, req1_b, req1_ctrl, rsp1_ready,
    input  alu_busW, alu_zero,
    output req0_ready, rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    output alu_busA, alu_busB, alu_ctrl
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_ctrl, rsp0_ready,
    output req1_valid, req1_a, req1_b, req1_ctrl, rsp1_ready,
    output alu_busW, alu_zero,
    input  req0_ready, rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    input  alu_busA, alu_busB, alu_ctrl
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer time-sharing one external combinational ALU between two requesters.
// Build macro ALU_OPCHECK_EN: illegal ctrl codes skip the ALU and answer with err=1.
module alu_arbiter #(
  parameter int WIDTH  = 64,
  parameter int CTRL_W = 4
) (
  input  logic         CLK,
  input  logic         Reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              owner_q, owner_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              zero_q, zero_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;

  logic              gnt0_s;
  logic              gnt1_s;
  logic              rsp_done_s;
  logic [WIDTH-1:0]  sel_a_s;
  logic [WIDTH-1:0]  sel_b_s;
  logic [CTRL_W-1:0] sel_ctrl_s;

`ifdef ALU_OPCHECK_EN
  logic              err_q, err_d;

  function automatic logic is_legal_op(input logic [CTRL_W-1:0] c);
    logic ok;
    case (c)
      CTRL_W'(4'b0000): ok = 1'b1;
      CTRL_W'(4'b0001): ok = 1'b1;
      CTRL_W'(4'b0010): ok = 1'b1;
      CTRL_W'(4'b0110): ok = 1'b1;
      CTRL_W'(4'b0111): ok = 1'b1;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction
`endif

  assign sel_a_s    = gnt1_s ? bus.req1_a    : bus.req0_a;
  assign sel_b_s    = gnt1_s ? bus.req1_b    : bus.req0_b;
  assign sel_ctrl_s = gnt1_s ? bus.req1_ctrl : bus.req0_ctrl;
  assign rsp_done_s = owner_q ? bus.rsp1_ready : bus.rsp0_ready;

  // Grant only in IDLE; on contention the requester that did not win last time goes first.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (state_q == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (last_grant_q) begin
          gnt0_s = 1'b1;
        end else begin
          gnt1_s = 1'b1;
        end
      end else begin
        gnt0_s = bus.req0_valid;
        gnt1_s = bus.req1_valid;
      end
    end else begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
    end
  end

  assign bus.req0_ready = gnt0_s;
  assign bus.req1_ready = gnt1_s;

  // Sequencer next state: accept in IDLE, sample the ALU in EXEC, hold the response in RESP.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    a_d          = a_q;
    b_d          = b_q;
    ctrl_d       = ctrl_q;
    result_d     = result_q;
    zero_d       = zero_q;
    rsp_valid_d  = rsp_valid_q;
`ifdef ALU_OPCHECK_EN
    err_d        = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt0_s || gnt1_s) begin
          a_d          = sel_a_s;
          b_d          = sel_b_s;
          ctrl_d       = sel_ctrl_s;
          owner_d      = gnt1_s;
          last_grant_d = gnt1_s;
`ifdef ALU_OPCHECK_EN
          if (is_legal_op(sel_ctrl_s)) begin
            state_d = EXEC;
            err_d   = 1'b0;
          end else begin
            // Illegal op never reaches the ALU result path; answer immediately.
            state_d     = RESP;
            result_d    = {WIDTH{1'b0}};
            zero_d      = 1'b0;
            err_d       = 1'b1;
            rsp_valid_d = gnt1_s ? 2'b10 : 2'b01;
          end
`else
          state_d = EXEC;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        result_d    = bus.alu_busW;
        zero_d      = bus.alu_zero;
        state_d     = RESP;
        rsp_valid_d = owner_q ? 2'b10 : 2'b01;
      end
      RESP: begin
        if (rsp_done_s) begin
          state_d     = IDLE;
          rsp_valid_d = 2'b00;
        end else begin
          state_d     = RESP;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 2'b00;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops any in-flight op.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      a_q          <= {WIDTH{1'b0}};
      b_q          <= {WIDTH{1'b0}};
      ctrl_q       <= {CTRL_W{1'b0}};
      result_q     <= {WIDTH{1'b0}};
      zero_q       <= 1'b0;
      rsp_valid_q  <= 2'b00;
`ifdef ALU_OPCHECK_EN
      err_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ctrl_q       <= ctrl_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      rsp_valid_q  <= rsp_valid_d;
`ifdef ALU_OPCHECK_EN
      err_q        <= err_d;
`endif
    end
  end

  assign bus.alu_busA = a_q;
  assign bus.alu_busB = b_q;
  assign bus.alu_ctrl = ctrl_q;

  assign bus.rsp0_valid  = rsp_valid_q[0];
  assign bus.rsp1_valid  = rsp_valid_q[1];
  assign bus.rsp0_result = rsp_valid_q[0] ? result_q : {WIDTH{1'b0}};
  assign bus.rsp1_result = rsp_valid_q[1] ? result_q : {WIDTH{1'b0}};
  assign bus.rsp0_zero   = rsp_valid_q[0] & zero_q;
  assign bus.rsp1_zero   = rsp_valid_q[1] & zero_q;
`ifdef ALU_OPCHECK_EN
  assign bus.rsp0_err    = rsp_valid_q[0] & err_q;
  assign bus.rsp1_err    = rsp_valid_q[1] & err_q;
`else
  assign bus.rsp0_err    = 1'b0;
  assign bus.rsp1_err    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, reset corner cases and
// randomized traffic against a round-robin/arithmetic reference model.
module tb_alu_arbiter;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;
  int   last_g;

`ifdef ALU_OPCHECK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  alu_arbiter_if #(.WIDTH(64), .CTRL_W(4)) bus_if ();

  alu_arbiter #(.WIDTH(64), .CTRL_W(4)) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: AND/ORR/ADD/SUB/PASSB, anything else yields 0.
  function automatic logic [63:0] alu_fn(input logic [63:0] a, input logic [63:0] b, input logic [3:0] c);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return b;
      default: return 64'd0;
    endcase
  endfunction

  assign bus_if.alu_busW = alu_fn(bus_if.alu_busA, bus_if.alu_busB, bus_if.alu_ctrl);
  assign bus_if.alu_zero = (bus_if.alu_busW == 64'd0);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [133:0] act_rsp();
    return {bus_if.rsp1_valid, bus_if.rsp0_valid, bus_if.rsp0_zero, bus_if.rsp0_err,
            bus_if.rsp1_zero, bus_if.rsp1_err, bus_if.rsp0_result, bus_if.rsp1_result};
  endfunction

  function automatic logic [133:0] exp_rsp(input int o, input logic [63:0] r, input bit z, input bit e);
    if (o == 0) return {1'b0, 1'b1, z, e, 1'b0, 1'b0, r, 64'd0};
    else        return {1'b1, 1'b0, 1'b0, 1'b0, z, e, 64'd0, r};
  endfunction

  function automatic void exp_of(input logic [63:0] a, input logic [63:0] b, input logic [3:0] c,
                                 output logic [63:0] r, output bit z, output bit e);
    bit legal;
    legal = (c == 4'd0) || (c == 4'd1) || (c == 4'd2) || (c == 4'd6) || (c == 4'd7);
    if (OPCHK && !legal) begin
      r = 64'd0; z = 1'b0; e = 1'b1;
    end else begin
      r = alu_fn(a, b, c); z = (r == 64'd0); e = 1'b0;
    end
  endfunction

  function automatic logic [1:0] ready_vec(input int own);
    if (own < 0) return 2'b00;
    return (own == 1) ? 2'b10 : 2'b01;
  endfunction

  // One full transaction from IDLE back to IDLE, with expected owner and response given.
  task automatic transact(input string nm, input bit v0, input bit v1,
                          input logic [63:0] a0, input logic [63:0] b0, input logic [3:0] c0,
                          input logic [63:0] a1, input logic [63:0] b1, input logic [3:0] c1,
                          input int hold, input int own, input logic [63:0] er, input bit ez, input bit ee);
    int lat;
    bus_if.req0_valid = v0; bus_if.req0_a = a0; bus_if.req0_b = b0; bus_if.req0_ctrl = c0;
    bus_if.req1_valid = v1; bus_if.req1_a = a1; bus_if.req1_b = b1; bus_if.req1_ctrl = c1;
    bus_if.rsp0_ready = 1'b0; bus_if.rsp1_ready = 1'b0;
    #1;
    chk({nm, " grant"}, {bus_if.req1_ready, bus_if.req0_ready}, ready_vec(own));
    if (own < 0) begin
      tick();
      chk({nm, " idle"}, act_rsp(), 134'd0);
      bus_if.req0_valid = 1'b0; bus_if.req1_valid = 1'b0;
      return;
    end
    tick();
    // Both requesters keep pushing new junk operands: none of it may be accepted or leak in.
    bus_if.req0_valid = 1'b1; bus_if.req1_valid = 1'b1;
    bus_if.req0_a = {$urandom, $urandom}; bus_if.req0_b = {$urandom, $urandom};
    bus_if.req1_a = {$urandom, $urandom}; bus_if.req1_b = {$urandom, $urandom};
    bus_if.req0_ctrl = 4'($urandom); bus_if.req1_ctrl = 4'($urandom);
    lat = 0;
    while (1) begin
      #1;
      chk({nm, " stall"}, {bus_if.req1_ready, bus_if.req0_ready}, 2'b00);
      if (bus_if.rsp0_valid || bus_if.rsp1_valid || lat >= 6) break;
      tick();
      lat++;
    end
    chk({nm, " latency"}, lat, ee ? 0 : 1);
    for (int h = 0; h < hold; h++) begin
      chk({nm, " hold"}, act_rsp(), exp_rsp(own, er, ez, ee));
      tick();
      #1;
      chk({nm, " hold stall"}, {bus_if.req1_ready, bus_if.req0_ready}, 2'b00);
    end
    if (own == 0) bus_if.rsp0_ready = 1'b1; else bus_if.rsp1_ready = 1'b1;
    #1;
    chk({nm, " rsp"}, act_rsp(), exp_rsp(own, er, ez, ee));
    chk({nm, " no accept in RESP"}, {bus_if.req1_ready, bus_if.req0_ready}, 2'b00);
    bus_if.req0_valid = 1'b0; bus_if.req1_valid = 1'b0;
    tick();
    bus_if.rsp0_ready = 1'b0; bus_if.rsp1_ready = 1'b0;
    #1;
    chk({nm, " done"}, act_rsp(), 134'd0);
  endtask

  // Reference model: round-robin grant and spec arithmetic on the accepted operands.
  task automatic model_run(input string nm, input bit v0, input bit v1,
                           input logic [63:0] a0, input logic [63:0] b0, input logic [3:0] c0,
                           input logic [63:0] a1, input logic [63:0] b1, input logic [3:0] c1, input int hold);
    int own;
    logic [63:0] r;
    bit z, e;
    if (v0 && v1) own = (last_g == 1) ? 0 : 1;
    else if (v0)  own = 0;
    else if (v1)  own = 1;
    else          own = -1;
    if (own == 0) exp_of(a0, b0, c0, r, z, e);
    else          exp_of(a1, b1, c1, r, z, e);
    if (own >= 0) last_g = own;
    transact(nm, v0, v1, a0, b0, c0, a1, b1, c1, hold, own, r, z, e);
  endtask

  typedef struct {
    bit          v0;
    bit          v1;
    logic [63:0] a0;
    logic [63:0] b0;
    logic [3:0]  c0;
    logic [63:0] a1;
    logic [63:0] b1;
    logic [3:0]  c1;
    int          hold;
    int          own;
    logic [63:0] res;
    bit          z;
  } vec_t;

  vec_t tbl[11];

  initial begin
    n_pass = 0;
    n_total = 0;
    last_g = 1;
    tbl[0]  = '{1'b1, 1'b0, 64'd5, 64'd3, 4'b0010, 64'd0, 64'd0, 4'b0000, 0, 0, 64'd8, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 64'd0, 64'd0, 4'b0000, 64'd7, 64'd7, 4'b0110, 0, 1, 64'd0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 64'hFF, 64'h0F, 4'b0000, 64'hF0, 64'h0F, 4'b0001, 0, 0, 64'h0F, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 64'hFF, 64'h0F, 4'b0000, 64'hF0, 64'h0F, 4'b0001, 0, 1, 64'hFF, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 64'hFF, 64'h0F, 4'b0000, 64'hF0, 64'h0F, 4'b0001, 0, 0, 64'h0F, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 64'hFF, 64'h0F, 4'b0000, 64'hF0, 64'h0F, 4'b0001, 0, 1, 64'hFF, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 64'd0, 64'd1, 4'b0110, 64'd0, 64'd0, 4'b0000, 5, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 64'd0, 64'd0, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'b0010, 1, 1, 64'd0, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 64'hDEAD, 64'h1234, 4'b0111, 64'd0, 64'd0, 4'b0000, 0, 0, 64'h1234, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 64'd0, 64'd0, 4'b0000, 64'hF0, 64'h0F, 4'b0000, 2, 1, 64'd0, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 64'd1, 64'd1, 4'b0010, 64'd1, 64'd1, 4'b0010, 0, -1, 64'd0, 1'b0};

    rst = 1'b1;
    bus_if.req0_valid = 1'b0; bus_if.req0_a = 64'd0; bus_if.req0_b = 64'd0; bus_if.req0_ctrl = 4'd0;
    bus_if.req1_valid = 1'b0; bus_if.req1_a = 64'd0; bus_if.req1_b = 64'd0; bus_if.req1_ctrl = 4'd0;
    bus_if.rsp0_ready = 1'b0; bus_if.rsp1_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    #1;
    chk("reset rsp", act_rsp(), 134'd0);
    chk("reset alu bus", {bus_if.alu_busA, bus_if.alu_busB, bus_if.alu_ctrl}, 132'd0);
    chk("reset ready idle", {bus_if.req1_ready, bus_if.req0_ready}, 2'b00);
    bus_if.req0_valid = 1'b1;
    #1;
    chk("reset ready req0", {bus_if.req1_ready, bus_if.req0_ready}, 2'b01);
    bus_if.req0_valid = 1'b0;

    for (int i = 0; i < 11; i++) begin
      transact($sformatf("vec%0d", i), tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].b0, tbl[i].c0,
               tbl[i].a1, tbl[i].b1, tbl[i].c1, tbl[i].hold, tbl[i].own, tbl[i].res, tbl[i].z, 1'b0);
    end
    last_g = 1;

    // Reset during EXEC: op is dropped, no response, round-robin pointer restored.
    bus_if.req1_valid = 1'b1; bus_if.req1_a = 64'd9; bus_if.req1_b = 64'd1; bus_if.req1_ctrl = 4'b0010;
    #1;
    tick();
    bus_if.req1_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst exec alu bus", {bus_if.alu_busA, bus_if.alu_busB, bus_if.alu_ctrl}, 132'd0);
    for (int i = 0; i < 4; i++) begin
      chk("rst exec no rsp", act_rsp(), 134'd0);
      tick();
    end
    bus_if.req0_valid = 1'b1; bus_if.req1_valid = 1'b1;
    #1;
    chk("rst exec grant", {bus_if.req1_ready, bus_if.req0_ready}, 2'b01);
    bus_if.req0_valid = 1'b0; bus_if.req1_valid = 1'b0;

    // Reset during RESP under back-pressure.
    bus_if.req1_valid = 1'b1;
    #1;
    tick();
    bus_if.req1_valid = 1'b0;
    tick();
    chk("rst resp pending", {bus_if.rsp1_valid, bus_if.rsp0_valid}, 2'b10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("rst resp no rsp", act_rsp(), 134'd0);
      tick();
    end
    last_g = 1;

    model_run("illegal op", 1'b0, 1'b1, 64'd0, 64'd0, 4'd0, 64'd9, 64'd4, 4'b0011, 1);
    model_run("illegal op0", 1'b1, 1'b0, 64'd3, 64'd3, 4'b1111, 64'd0, 64'd0, 4'd0, 0);

    for (int i = 0; i < 150; i++) begin
      logic [3:0] c0, c1;
      bit v0, v1;
      int pick;
      pick = $urandom_range(0, 9);
      v0 = (pick < 7) ? $urandom_range(0, 1) : 1'b1;
      v1 = (pick < 7) ? $urandom_range(0, 1) : 1'b1;
      c0 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 2));
      c1 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(6, 7));
      model_run($sformatf("rand%0d", i), v0, v1,
                {$urandom, $urandom}, {$urandom, $urandom}, c0,
                {$urandom, $urandom}, ($urandom_range(0, 4) == 0) ? 64'd0 : {$urandom, $urandom}, c1,
                $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
